// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns EX/MEM load/store into a req/ack memory transaction,
// stalls upstream while busy, and registers MEM/WB outputs. Optional: MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              call_in,
  input  logic              mem_to_reg_in,
  input  logic [3:0]        reg_rd_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] save_word_data_in,
  input  logic              ret_future_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              valid_out,
  output logic              RegWrite_out,
  output logic [3:0]        reg_rd_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              call_out,
  output logic              ret_out,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              regw_q, regw_d;
  logic [3:0]        rd_q, rd_d;
  logic [DATA_W-1:0] wb_q, wb_d;
  logic              call_q, call_d;
  logic              ret_q, ret_d;
  logic              stall_c;
  logic              access;
  logic              timed_out;

  assign access = MemRead_in | MemWrite_in;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign timed_out = to_q;
  assign mem_err   = err_q;
`else
  assign timed_out = 1'b0;
  assign mem_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    regw_d  = regw_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    call_d  = call_q;
    ret_d   = ret_q;
    stall_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
    err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (access) begin
          // Write wins when both strobes are set; MEM/WB sees a bubble meanwhile.
          stall_c = 1'b1;
          state_d = BUSY;
          addr_d  = alu_result_in[ADDR_W-1:0];
          wdata_d = save_word_data_in;
          we_d    = MemWrite_in;
          valid_d = 1'b0;
          regw_d  = 1'b0;
          call_d  = 1'b0;
          ret_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
          to_d    = 1'b0;
`endif
        end else begin
          valid_d = 1'b1;
          regw_d  = RegWrite_in;
          rd_d    = reg_rd_in;
          wb_d    = alu_result_in;
          call_d  = call_in;
          ret_d   = ret_future_in;
        end
      end

      BUSY: begin
        stall_c = 1'b1;
        valid_d = 1'b0;
        regw_d  = 1'b0;
        call_d  = 1'b0;
        ret_d   = 1'b0;
        if (mem_ack) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      DONE: begin
        // EX/MEM still holds the completed instruction; retire it without re-issuing.
        state_d = IDLE;
        valid_d = 1'b1;
        regw_d  = RegWrite_in & ~timed_out;
        rd_d    = reg_rd_in;
        call_d  = call_in;
        ret_d   = ret_future_in;
        if (timed_out)          wb_d = '0;
        else if (mem_to_reg_in) wb_d = rdata_q;
        else                    wb_d = alu_result_in;
`ifdef MEM_TIMEOUT_EN
        err_d   = to_q;
        to_d    = 1'b0;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      regw_q  <= 1'b0;
      rd_q    <= '0;
      wb_q    <= '0;
      call_q  <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      regw_q  <= regw_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      call_q  <= call_d;
      ret_q   <= ret_d;
    end
  end

  // Request and stall must fall the instant reset is raised.
  assign mem_req      = (state_q == BUSY);
  assign stall        = stall_c & ~rst;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign valid_out    = valid_q;
  assign RegWrite_out = regw_q;
  assign reg_rd_out   = rd_q;
  assign wb_data_out  = wb_q;
  assign call_out     = call_q;
  assign ret_out      = ret_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed instructions push expected MEM/WB
// records; a monitor pops them on valid_out, a memory model checks requests.
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  typedef struct packed {
    logic        rw, mw, mr, call, m2r, ret;
    logic [3:0]  rd;
    logic [15:0] alu, sw;
  } instr_t;

  typedef struct packed {
    logic        rw;
    logic [3:0]  rd;
    logic [15:0] wb;
    logic        call, ret, err;
  } exp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } req_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        RegWrite_in = 0, MemWrite_in = 0, MemRead_in = 0, call_in = 0;
  logic        mem_to_reg_in = 0, ret_future_in = 0;
  logic [3:0]  reg_rd_in = 0;
  logic [15:0] alu_result_in = 0, save_word_data_in = 0;
  logic        mem_req, mem_we, mem_ack, stall, valid_out, RegWrite_out;
  logic        call_out, ret_out, mem_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, wb_data_out;
  logic [3:0]  reg_rd_out;

  int checks = 0, fails = 0;
  exp_t exp_q[$];
  req_t req_q[$];
  int   ack_delay = 0;
  logic [15:0] ack_rdata = 0;
  logic force_ack = 0;
  int   last_req_len = 0;

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .call_in(call_in), .mem_to_reg_in(mem_to_reg_in), .reg_rd_in(reg_rd_in),
    .alu_result_in(alu_result_in), .save_word_data_in(save_word_data_in),
    .ret_future_in(ret_future_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .valid_out(valid_out),
    .RegWrite_out(RegWrite_out), .reg_rd_out(reg_rd_out), .wb_data_out(wb_data_out),
    .call_out(call_out), .ret_out(ret_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid MEM/WB output must match the oldest expected record.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        a = '{RegWrite_out, reg_rd_out, wb_data_out, call_out, ret_out, mem_err};
        if (exp_q.size() == 0) chk("unexpected_output", 64'(a), 64'hDEAD);
        else begin
          e = exp_q.pop_front();
          chk("wb_record", 64'(a), 64'(e));
        end
      end
    end
  end

  // Memory model: checks held request fields each BUSY cycle, acks after ack_delay cycles.
  initial begin
    int   cnt = 0;
    logic prev = 0, ack;
    mem_ack = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      #2;
      ack = 1'b0;
      if (mem_req) begin
        if (req_q.size() == 0) chk("unexpected_req", 64'(mem_addr), 64'hDEAD);
        else chk("req_fields", 64'({mem_addr, mem_we, mem_wdata}), 64'(req_q[0]));
        cnt++;
        ack = (ack_delay != 0) && (cnt == ack_delay);
      end else begin
        if (prev) begin
          last_req_len = cnt;
          if (req_q.size() != 0) void'(req_q.pop_front());
        end
        cnt = 0;
      end
      mem_ack = ack | force_ack;
      mem_rdata = ack ? ack_rdata : 16'h0000;
      prev = mem_req;
    end
  end

  task automatic issue(input instr_t in, input int exp_stall, input exp_t ex);
    logic s;
    int   n = 0;
    bit   done = 0;
    {RegWrite_in, MemWrite_in, MemRead_in, call_in, mem_to_reg_in, ret_future_in} =
      {in.rw, in.mw, in.mr, in.call, in.m2r, in.ret};
    reg_rd_in = in.rd;
    alu_result_in = in.alu;
    save_word_data_in = in.sw;
    for (int i = 0; i < 300; i++) begin
      #1 s = stall;
      @(posedge clk);
      if (!s) begin
        done = 1;
        break;
      end
      n++;
      #1 chk("bubble_valid", 64'(valid_out), 64'd0);
      @(negedge clk);
    end
    if (!done) chk("issue_timeout", 64'd0, 64'd1);
    else exp_q.push_back(ex);
    chk("stall_cycles", 64'(n), 64'(exp_stall));
    @(negedge clk);
  endtask

  initial begin
    instr_t nop = '0;
    #12;
    chk("rst_outs", 64'({mem_req, mem_we, stall, valid_out, RegWrite_out, call_out,
                         ret_out, mem_err}), 64'd0);
    chk("rst_data", 64'({mem_addr, mem_wdata, reg_rd_out, wb_data_out}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU ops
    issue('{rw:1, mw:0, mr:0, call:0, m2r:0, ret:0, rd:5, alu:16'h1234, sw:0}, 0,
          '{rw:1, rd:5, wb:16'h1234, call:0, ret:0, err:0});
    issue('{rw:1, mw:0, mr:0, call:1, m2r:0, ret:1, rd:4'hF, alu:16'hFFFF, sw:0}, 0,
          '{rw:1, rd:4'hF, wb:16'hFFFF, call:1, ret:1, err:0});

    // Load, ack on third BUSY cycle
    req_q.push_back('{addr:16'h0040, we:0, wdata:16'h0000});
    ack_delay = 3; ack_rdata = 16'hBEEF;
    issue('{rw:1, mw:0, mr:1, call:0, m2r:1, ret:0, rd:3, alu:16'h0040, sw:0}, 4,
          '{rw:1, rd:3, wb:16'hBEEF, call:0, ret:0, err:0});
    chk("load_req_len", 64'(last_req_len), 64'd3);

    // Store, single-cycle ack
    req_q.push_back('{addr:16'h0010, we:1, wdata:16'hCAFE});
    ack_delay = 1; ack_rdata = 16'h9999;
    issue('{rw:1, mw:1, mr:0, call:0, m2r:0, ret:0, rd:7, alu:16'h0010, sw:16'hCAFE}, 2,
          '{rw:1, rd:7, wb:16'h0010, call:0, ret:0, err:0});
    chk("store_req_len", 64'(last_req_len), 64'd1);

    // Load with ALU write-back selected
    req_q.push_back('{addr:16'h00A0, we:0, wdata:16'h0000});
    ack_delay = 2; ack_rdata = 16'h7777;
    issue('{rw:1, mw:0, mr:1, call:0, m2r:0, ret:0, rd:9, alu:16'h00A0, sw:0}, 3,
          '{rw:1, rd:9, wb:16'h00A0, call:0, ret:0, err:0});

    // Read and write together: a single write access
    req_q.push_back('{addr:16'h0022, we:1, wdata:16'h5A5A});
    ack_delay = 2; ack_rdata = 16'h1111;
    issue('{rw:0, mw:1, mr:1, call:0, m2r:0, ret:0, rd:4, alu:16'h0022, sw:16'h5A5A}, 3,
          '{rw:0, rd:4, wb:16'h0022, call:0, ret:0, err:0});
    chk("both_req_len", 64'(last_req_len), 64'd2);

    // Stray ack while idle
    force_ack = 1'b1;
    issue(nop, 0, '{rw:0, rd:0, wb:0, call:0, ret:0, err:0});
    force_ack = 1'b0;
    chk("stray_ack_req", 64'(mem_req), 64'd0);
    issue('{rw:1, mw:0, mr:0, call:0, m2r:0, ret:0, rd:2, alu:16'h0077, sw:0}, 0,
          '{rw:1, rd:2, wb:16'h0077, call:0, ret:0, err:0});

    // Reset in the middle of a BUSY phase
    req_q.push_back('{addr:16'h0050, we:0, wdata:16'h0000});
    ack_delay = 0;
    {RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in} = 4'b1011;
    reg_rd_in = 4'd2; alu_result_in = 16'h0050; save_word_data_in = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    #1 chk("busy_req", 64'(mem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctrl", 64'({mem_req, mem_we, stall, valid_out, RegWrite_out, call_out,
                            ret_out, mem_err}), 64'd0);
    chk("midrst_data", 64'({mem_addr, mem_wdata, reg_rd_out, wb_data_out}), 64'd0);
    {RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in} = 4'b0000;
    reg_rd_in = 0; alu_result_in = 0;
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    issue(nop, 0, '{rw:0, rd:0, wb:0, call:0, ret:0, err:0});
    force_ack = 1'b0;
    chk("postrst_req", 64'(mem_req), 64'd0);
    issue('{rw:1, mw:0, mr:0, call:0, m2r:0, ret:0, rd:4'hA, alu:16'h0BAD, sw:0}, 0,
          '{rw:1, rd:4'hA, wb:16'h0BAD, call:0, ret:0, err:0});

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after TIMEOUT BUSY cycles
    req_q.push_back('{addr:16'h0030, we:0, wdata:16'h0000});
    ack_delay = 0;
    issue('{rw:1, mw:0, mr:1, call:0, m2r:1, ret:0, rd:6, alu:16'h0030, sw:0}, 1 + TMO,
          '{rw:0, rd:6, wb:16'h0000, call:0, ret:0, err:1});
    chk("timeout_req_len", 64'(last_req_len), 64'(TMO));
    issue(nop, 0, '{rw:0, rd:0, wb:0, call:0, ret:0, err:0});
`endif

    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
    chk("req_drained", 64'(req_q.size()), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
